// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared op, funct3 and compare-flag encodings for the execute stage
package core_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_JAL  = 2'b10;
  localparam logic [1:0] OP_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flags bus is ordered {V,C,N,Z}
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {ST_RUN, ST_REDIR} br_state_t;

endpackage

// File: rtl/branch_flags.sv
// rtl/branch_flags.sv - combinational rs1 - rs2 subtractor producing {V,C,N,Z}
module branch_flags #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      flags
);
  import core_pkg::*;

  logic [XLEN:0] diff;

  always_comb begin
    // Carry out of rs1 + ~rs2 + 1 is set exactly when rs1 >= rs2 unsigned
    diff = {1'b0, rs1} + {1'b0, ~rs2} + {{XLEN{1'b0}}, 1'b1};
    flags = '0;
    flags[FLAG_Z] = (diff[XLEN-1:0] == '0);
    flags[FLAG_N] = diff[XLEN-1];
    flags[FLAG_C] = diff[XLEN];
    flags[FLAG_V] = (rs1[XLEN-1] ^ rs2[XLEN-1]) & (diff[XLEN-1] ^ rs1[XLEN-1]);
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - two-stage branch/jump resolution with fetch redirect and squash
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_link,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_target
);
  import core_pkg::*;

  logic            e1_valid;
  logic [1:0]      e1_op;
  logic [2:0]      e1_f3;
  logic [3:0]      e1_flags;
  logic [XLEN-1:0] e1_target;
  logic [XLEN-1:0] e1_link;

  logic            e2_valid;
  logic [1:0]      e2_op;
  logic [2:0]      e2_f3;
  logic [3:0]      e2_flags;
  logic [XLEN-1:0] e2_target;
  logic [XLEN-1:0] e2_link;
  logic            e2_redirected;

  br_state_t       state;
  logic            alive;
  logic [XLEN-1:0] redir_hold;

  logic [3:0]      in_flags;
  logic [XLEN-1:0] in_target;
  logic            cond;
  logic            e2_taken;
  logic            raise;
  logic            retire;
  logic            e2_load;
  logic            e1_adv;
  logic            accept;

  branch_flags #(.XLEN(XLEN)) u_flags (
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .flags (in_flags)
  );

  always_comb begin
    if (in_op == OP_JALR)
      in_target = (in_rs1 + in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    else
      in_target = in_pc + in_imm;
  end

  always_comb begin
    case (e2_f3)
      F3_BEQ:  cond = e2_flags[FLAG_Z];
      F3_BNE:  cond = ~e2_flags[FLAG_Z];
      F3_BLT:  cond = e2_flags[FLAG_N] ^ e2_flags[FLAG_V];
      F3_BGE:  cond = ~(e2_flags[FLAG_N] ^ e2_flags[FLAG_V]);
      F3_BLTU: cond = ~e2_flags[FLAG_C];
      F3_BGEU: cond = e2_flags[FLAG_C];
      default: cond = 1'b0;
    endcase
  end

  assign e2_taken = ((e2_op == OP_BR) & cond) | (e2_op == OP_JAL) | (e2_op == OP_JALR);
  assign retire   = e2_valid & out_ready;
  // Redirect fires once per entry; the redirected bit covers a long out_ready stall
  assign raise    = (state == ST_RUN) & e2_valid & e2_taken & ~e2_redirected;
  assign e2_load  = ~e2_valid | retire;
  assign e1_adv   = e1_valid & e2_load;
  assign in_ready = alive & (state == ST_RUN) & ~raise & (~e1_valid | e1_adv);
  assign accept   = in_valid & in_ready;

  assign out_valid    = e2_valid;
  assign out_taken    = e2_valid & e2_taken;
  assign out_link     = e2_link;
  assign redir_valid  = raise | (state == ST_REDIR);
  assign redir_target = (state == ST_REDIR) ? redir_hold : e2_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      alive         <= 1'b0;
      state         <= ST_RUN;
      redir_hold    <= '0;
      e1_valid      <= 1'b0;
      e1_op         <= OP_NONE;
      e1_f3         <= '0;
      e1_flags      <= '0;
      e1_target     <= '0;
      e1_link       <= '0;
      e2_valid      <= 1'b0;
      e2_op         <= OP_NONE;
      e2_f3         <= '0;
      e2_flags      <= '0;
      e2_target     <= '0;
      e2_link       <= '0;
      e2_redirected <= 1'b0;
    end else begin
      alive <= 1'b1;

      if (raise) begin
        e1_valid <= 1'b0;
      end else if (accept) begin
        e1_valid  <= 1'b1;
        e1_op     <= in_op;
        e1_f3     <= in_funct3;
        e1_flags  <= in_flags;
        e1_target <= in_target;
        e1_link   <= in_pc + {{(XLEN-3){1'b0}}, 3'd4};
      end else if (e1_adv) begin
        e1_valid <= 1'b0;
      end

      if (e2_load) begin
        e2_valid      <= e1_valid & ~raise;
        e2_op         <= e1_op;
        e2_f3         <= e1_f3;
        e2_flags      <= e1_flags;
        e2_target     <= e1_target;
        e2_link       <= e1_link;
        e2_redirected <= 1'b0;
      end else if (raise) begin
        e2_redirected <= 1'b1;
      end

      if (state == ST_RUN) begin
        if (raise & ~redir_ready) begin
          state      <= ST_REDIR;
          redir_hold <= e2_target;
        end
      end else if (redir_ready) begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed and randomized self-checking bench for branch_resolve
module tb_branch_resolve;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_link;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_target;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        taken;
    logic [31:0] link;
  } exp_t;

  exp_t        exp_q[$];
  logic        pend_valid;
  logic        pend_raised;
  logic [31:0] pend_target;

  branch_resolve #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_funct3    (in_funct3),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_taken    (out_taken),
    .out_link     (out_link),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_target (redir_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of each instruction, straight from the ISA rules
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       output logic tk, output logic [31:0] tg, output logic [31:0] lk);
    logic c;
    case (f3)
      3'd0:    c = (rs1 == rs2);
      3'd1:    c = (rs1 != rs2);
      3'd4:    c = ($signed(rs1) < $signed(rs2));
      3'd5:    c = ($signed(rs1) >= $signed(rs2));
      3'd6:    c = (rs1 < rs2);
      3'd7:    c = (rs1 >= rs2);
      default: c = 1'b0;
    endcase
    tk = ((op == 2'b01) && c) || (op == 2'b10) || (op == 2'b11);
    tg = (op == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    lk = pc + 32'd4;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_funct3 = f3;
    in_pc     = pc;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic run_one(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
    logic tk;
    logic [31:0] tg, lk;
    model(op, f3, pc, rs1, rs2, imm, tk, tg, lk);
    @(negedge clk);
    drive(op, f3, pc, rs1, rs2, imm);
    out_ready   = 1'b1;
    redir_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat1_out_valid"}, out_valid, 0);
    @(negedge clk);
    #1;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_taken"}, out_taken, tk);
    check({tag, "_out_link"}, out_link, lk);
    check({tag, "_redir_valid"}, redir_valid, tk);
    if (tk) check({tag, "_redir_target"}, redir_target, tg);
    @(negedge clk);
    #1;
    check({tag, "_after_out_valid"}, out_valid, 0);
    check({tag, "_after_redir_valid"}, redir_valid, 0);
  endtask

  task automatic step(input bit drain);
    logic acc, ret, rh, tk;
    logic [31:0] tg, lk;
    @(negedge clk);
    drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
          $urandom, $urandom, 32'($urandom_range(0, 4095)) - 32'd2048);
    if ($urandom_range(0, 2) == 0) in_rs2 = in_rs1;
    in_valid    = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
    out_ready   = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    redir_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    acc = in_valid & in_ready;
    ret = out_valid & out_ready;
    rh  = redir_valid & redir_ready;
    if (out_valid) begin
      check("rnd_out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("rnd_out_taken", out_taken, exp_q[0].taken);
        check("rnd_out_link", out_link, exp_q[0].link);
        if (ret) void'(exp_q.pop_front());
      end
    end
    if (redir_valid) begin
      check("rnd_redir_expected", pend_valid, 1);
      check("rnd_in_ready_blocked", in_ready, 0);
      if (pend_valid) begin
        check("rnd_redir_target", redir_target, pend_target);
        pend_raised = 1'b1;
        if (rh) pend_valid = 1'b0;
      end
    end
    // Anything accepted behind a taken instruction, before its redirect shows, is wrong-path
    if (acc && !(pend_valid && !pend_raised)) begin
      model(in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm, tk, tg, lk);
      exp_q.push_back('{taken: tk, link: lk});
      if (tk) begin
        pend_valid  = 1'b1;
        pend_raised = 1'b0;
        pend_target = tg;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_funct3 = 3'b000;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    out_ready = 1'b0; redir_ready = 1'b0;
    pend_valid = 1'b0; pend_raised = 1'b0; pend_target = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_taken", out_taken, 0);
    check("rst_out_link", out_link, 0);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_redir_target", redir_target, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_cycle_in_ready", in_ready, 0);
    @(posedge clk);
    #1 check("post_rst_in_ready", in_ready, 1);

    run_one("beq_eq",    2'b01, 3'b000, 32'h100, 32'h1234, 32'h1234, 32'h40);
    run_one("bne_eq",    2'b01, 3'b001, 32'h100, 32'h1234, 32'h1234, 32'h40);
    run_one("blt_neg",   2'b01, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10);
    run_one("bltu_neg",  2'b01, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10);
    run_one("blt_ovf",   2'b01, 3'b100, 32'h300, 32'h8000_0000, 32'h1, 32'hFFFF_FFF0);
    run_one("bge_ovf",   2'b01, 3'b101, 32'h300, 32'h8000_0000, 32'h1, 32'hFFFF_FFF0);
    run_one("bgeu_big",  2'b01, 3'b111, 32'h340, 32'hFFFF_FFFF, 32'h1, 32'h20);
    run_one("bltu_small",2'b01, 3'b110, 32'h340, 32'h1, 32'hFFFF_FFFF, 32'h20);
    run_one("jalr",      2'b11, 3'b011, 32'h400, 32'h1001, 32'h0, 32'h2);
    run_one("jal_back",  2'b10, 3'b010, 32'h500, 32'h0, 32'h0, 32'hFFFF_FF00);
    run_one("br_f3_010", 2'b01, 3'b010, 32'h600, 32'h0, 32'h5, 32'h8);
    run_one("br_f3_011", 2'b01, 3'b011, 32'h600, 32'h0, 32'h5, 32'h8);
    run_one("op_none",   2'b00, 3'b000, 32'h700, 32'h7, 32'h7, 32'h8);

    // Taken branch with a younger instruction right behind it and a slow fetch
    @(negedge clk);
    drive(2'b01, 3'b000, 32'h200, 32'h55, 32'h55, 32'h80);
    out_ready = 1'b1; redir_ready = 1'b0;
    @(negedge clk);
    drive(2'b00, 3'b000, 32'h204, 32'h0, 32'h0, 32'h0);
    #1 check("sq_young_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("sq_redir_valid_0", redir_valid, 1);
    check("sq_redir_target_0", redir_target, 32'h280);
    check("sq_in_ready_0", in_ready, 0);
    check("sq_out_taken", out_taken, 1);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("sq_redir_valid_%0d", i), redir_valid, 1);
      check($sformatf("sq_redir_target_%0d", i), redir_target, 32'h280);
      check($sformatf("sq_in_ready_%0d", i), in_ready, 0);
      check($sformatf("sq_squashed_%0d", i), out_valid, 0);
    end
    @(negedge clk);
    redir_ready = 1'b1;
    #1;
    check("sq_redir_accept_valid", redir_valid, 1);
    check("sq_redir_accept_in_ready", in_ready, 0);
    check("sq_redir_accept_out_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("sq_resume_in_ready", in_ready, 1);
    check("sq_resume_redir_valid", redir_valid, 0);
    check("sq_resume_out_valid", out_valid, 0);

    // Reset while a redirect is stuck and the E2 entry is stalled
    @(negedge clk);
    drive(2'b10, 3'b000, 32'h300, 32'h0, 32'h0, 32'h10);
    out_ready = 1'b0; redir_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 check("rr_redir_first", redir_valid, 1);
    @(negedge clk);
    #1 check("rr_redir_held", redir_valid, 1);
    check("rr_out_held", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rr_redir_dropped", redir_valid, 0);
    check("rr_out_dropped", out_valid, 0);
    check("rr_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 check("rr_in_ready_back", in_ready, 1);

    for (int i = 0; i < 3000; i++) step(1'b0);
    for (int i = 0; i < 30; i++) step(1'b1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_redirect_done", pend_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

- Execute-stage branch/jump resolution unit with two pipeline stages.
- Subtracts rs2 from rs1 to produce the {V,C,N,Z} compare flags, then evaluates the RISC-V branch condition selected by funct3.
- Computes the branch/jump target and link address.
- Raises a redirect request towards fetch when control flow leaves the not-taken path; while that redirect is outstanding it squashes and blocks younger instructions.

## Interface
Parameters:
- XLEN, 32, datapath width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  issue slot holds an instruction
- in_ready  out  1  unit accepts the instruction this cycle
- in_op  in  2  00 = none (pass-through), 01 = branch, 10 = JAL, 11 = JALR
- in_funct3  in  3  branch condition code
- in_pc, in_rs1, in_rs2, in_imm  in  XLEN  operands
- out_valid  out  1  resolved result available
- out_ready  in  1  consumer (writeback) accepts
- out_taken  out  1  control flow redirected
- out_link  out  XLEN  pc+4, for rd writeback of JAL/JALR
- redir_valid  out  1  fetch redirect request
- redir_ready  in  1  fetch accepts redirect
- redir_target  out  XLEN  new PC

## Operation
Stage E1 captures each accepted input (in_valid & in_ready). It registers the following:
- diff = rs1 − rs2, computed as rs1 + ~rs2 + 1 in XLEN+1 bits.
- Z = (diff == 0); N = diff[XLEN−1]; C = carry out (1 ⇔ rs1 ≥ rs2 unsigned).
- V = (rs1[msb] ^ rs2[msb]) & (diff[msb] ^ rs1[msb]).
- Target: pc + imm for branch/JAL; (rs1 + imm) & ~1 for JALR. Link = pc + 4.

Stage E2 evaluates the condition combinationally from its registered flags and funct3:
- 000 → Z; 001 → ~Z; 100 → N^V; 101 → ~(N^V); 110 → ~C; 111 → C.
- 010 and 011 → 0 (never taken; no latch).
- taken = (op == branch & cond) | op ∈ {JAL, JALR}. op none → taken = 0.

The FSM has two states, RUN and REDIR. Reset state is RUN.
- **RUN, E2 valid & taken, first cycle:** assert redir_valid with redir_target. E1 is squashed (E1 valid cleared at this edge). in_ready = 0.
- **Redirect accepted that cycle (redir_ready = 1):** remain in RUN.
- **Redirect not accepted:** go to REDIR.
- **REDIR:** hold redir_valid and redir_target stable; in_ready = 0; further E1 capture is inhibited. Return to RUN on redir_ready.
- **Entry-to-redirect rule:** a redirect is raised exactly once per taken E2 entry. A per-entry "redirected" bit prevents re-raising it while that entry waits on out_ready.

Pipeline flow:
- out_valid = E2 valid. The E2 entry retires on out_valid & out_ready.
- E2 loads from E1 when E2 is empty or retiring.
- in_ready = ~E1 valid | E1 advancing, gated low by redirect activity as above.

## Timing
- Latency: input accepted in cycle t → out_valid and (if taken) redir_valid in cycle t+2.
- Throughput: one instruction per cycle when not taken and out_ready = 1.
- A taken branch costs at least 1 bubble, plus every cycle redir_ready stays low.
- Reset values of all outputs:
  - 0: in_ready, out_valid, out_taken, out_link, redir_valid, redir_target.
  - E1/E2 valids = 0; FSM = RUN.
- in_ready is 0 during the reset cycle and is 1 from the first cycle after reset.
- Reset mid-REDIR: the redirect is dropped immediately (redir_valid = 0 next cycle) and all in-flight entries are discarded.
- Simultaneous E2 retire and E1→E2 advance in the same cycle: allowed; there is no bubble.
- Simultaneous out_ready and redir_ready in the first taken cycle: both handshakes complete; the FSM stays in RUN.
- out_valid held with out_ready low: out_taken, out_link and redir_target stay stable.

## Structure
- Shared package `core_pkg`:
  - op encoding constants: OP_NONE, OP_BR, OP_JAL, OP_JALR.
  - funct3 branch codes: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - flag bit indices: V = 3, C = 2, N = 1, Z = 0 (4-bit flags bus ordered {V,C,N,Z}).
- One sub-module, `branch_flags`: purely combinational subtractor producing the {V,C,N,Z} flags from rs1 and rs2.
- The FSM, the two pipeline registers, and the condition decode stay in `branch_resolve`.

## Test plan
- BEQ with rs1 = rs2 = 0x1234 → Z = 1, out_taken = 1, redir_target = pc + imm at t+2. BNE with the same operands → not taken, no redir_valid.
- BLT rs1 = 0xFFFFFFFF, rs2 = 1 → taken (N^V = 1). BLTU with the same operands → not taken (C = 1).
- BLT rs1 = 0x80000000, rs2 = 1 → V = 1, N = 0, taken. BGE with the same operands → not taken.
- JALR rs1 = 0x1001, imm = 2 → redir_target = 0x1002, out_link = pc + 4, taken regardless of funct3. funct3 = 010 branch → never taken.
- Taken branch followed back-to-back by another instruction, redir_ready low for 3 cycles:
  - the younger instruction in E1 is squashed (never reaches out_valid);
  - in_ready stays 0 and redir_valid/redir_target stay stable for 3 cycles;
  - in_ready returns to 1 the cycle after redir_ready.
- Assert rst while in REDIR → next cycle redir_valid = 0, out_valid = 0, in_ready = 0. The cycle after, in_ready = 1.
